// File: rtl/onehot_sel_pkg.sv
// ---------------------------------------------------------------------------
// onehot_sel_pkg
// Shared types and helpers for the round-robin one-hot select arbiter.
//   sel_state_e     : arbiter FSM state (IDLE, GRANT)
//   onehot_to_idx() : binary index of the set bit of a one-hot vector of up
//                     to MAX_PORTS bits; used by the arbiter's checkers.
// ---------------------------------------------------------------------------
package onehot_sel_pkg;

   localparam int MAX_PORTS = 16;
   localparam int MAX_IDX_W = 4;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } sel_state_e;

   // OR-ing the indices of all set bits gives the exact index for a one-hot
   // input and 0 for an all-zero input; no priority chain is needed.
   function automatic logic [MAX_IDX_W-1:0] onehot_to_idx(input logic [MAX_PORTS-1:0] oh);
      logic [MAX_IDX_W-1:0] idx;
      idx = '0;
      for (int i = 0; i < MAX_PORTS; i++) begin
         if (oh[i]) begin
            idx = idx | MAX_IDX_W'(i);
         end
      end
      return idx;
   endfunction

endpackage

// File: rtl/onehot_sel_arbiter_if.sv
// ---------------------------------------------------------------------------
// onehot_sel_arbiter_if
// Request / select bus between the requesters, the arbiter and the one-hot
// multiplexer that consumes the select.
//   req_i     : level request per port
//   done_i    : consumer pulse, current grant finished
//   sel_o     : registered one-hot select (all-zero when no grant is held)
//   sel_idx_o : binary index of the set bit of sel_o (0 when none)
//   sel_vld_o : high exactly when sel_o is non-zero
// Modports:
//   master : arbiter side (drives the select outputs)
//   slave  : requester/consumer side (drives req_i and done_i)
// ---------------------------------------------------------------------------
interface onehot_sel_arbiter_if #(
   parameter int NUM_PORTS = 4
);
   localparam int IDX_W = $clog2(NUM_PORTS);

   logic [NUM_PORTS-1:0] req_i;
   logic                 done_i;
   logic [NUM_PORTS-1:0] sel_o;
   logic [IDX_W-1:0]     sel_idx_o;
   logic                 sel_vld_o;

   modport master (
      input  req_i,
      input  done_i,
      output sel_o,
      output sel_idx_o,
      output sel_vld_o
   );

   modport slave (
      output req_i,
      output done_i,
      input  sel_o,
      input  sel_idx_o,
      input  sel_vld_o
   );

endinterface

// File: rtl/onehot_sel_arbiter_rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
// Combinational round-robin pick: the first set bit of req scanning upward
// from last_ptr+1, wrapping from NUM_PORTS-1 to 0. If only the port at
// last_ptr requests, it wins after a full wrap.
//   req      : request vector
//   last_ptr : index of the most recently released grant
//   winner   : index of the chosen port (don't-care when any_vld is 0)
//   any_vld  : at least one request present
// ---------------------------------------------------------------------------
module rr_pick #(
   parameter int NUM_PORTS = 4,
   parameter int IDX_W     = $clog2(NUM_PORTS)
) (
   input  logic [NUM_PORTS-1:0] req,
   input  logic [IDX_W-1:0]     last_ptr,
   output logic [IDX_W-1:0]     winner,
   output logic                 any_vld
);

   // One extra bit holds last_ptr+1 (up to NUM_PORTS) and the rotated sum
   // (up to 2*NUM_PORTS-1).
   localparam int              SUM_W   = IDX_W + 1;
   localparam logic [SUM_W-1:0] PORTS_W = SUM_W'(NUM_PORTS);

   logic [2*NUM_PORTS-1:0] req_dbl;
   logic [SUM_W-1:0]       start;
   logic [NUM_PORTS-1:0]   rot;
   logic [IDX_W-1:0]       offset;
   logic [SUM_W-1:0]       sum_raw;

   assign req_dbl = {req, req};
   assign start   = {1'b0, last_ptr} + SUM_W'(1);

   // Rotate so that rot[0] is the highest-priority port. Reading from the
   // doubled vector removes any explicit modulo on the index.
   genvar gi;
   generate
      for (gi = 0; gi < NUM_PORTS; gi++) begin : g_rot
         assign rot[gi] = req_dbl[start + SUM_W'(gi)];
      end
   endgenerate

   // Lowest set bit of the rotated vector; the downward loop lets the
   // lowest index overwrite any higher one.
   always_comb begin
      offset = '0;
      for (int k = NUM_PORTS - 1; k >= 0; k--) begin
         if (rot[k]) begin
            offset = IDX_W'(k);
         end
      end
   end

   // Undo the rotation: winner = (last_ptr + 1 + offset) mod NUM_PORTS.
   assign sum_raw = start + {1'b0, offset};

   always_comb begin
      if (sum_raw >= PORTS_W) begin
         winner = IDX_W'(sum_raw - PORTS_W);
      end else begin
         winner = IDX_W'(sum_raw);
      end
   end

   assign any_vld = |req;

endmodule

// File: rtl/onehot_sel_arbiter.sv
// ---------------------------------------------------------------------------
// onehot_sel_arbiter
// Round-robin arbiter producing a registered, strictly one-hot select for a
// one-hot multiplexer. A grant is held until the consumer pulses done_i or
// the owner drops its request; priority then rotates past the released port.
// One idle cycle with an all-zero select always separates two grants, so a
// make-before-break select cannot occur.
// Parameters:
//   NUM_PORTS : number of requesters / select width, legal range 2..16
// Ports:
//   clk   : clock, all state changes on the rising edge
//   reset : synchronous active-high reset
//   bus   : onehot_sel_arbiter_if.master (req_i, done_i in; sel_o,
//           sel_idx_o, sel_vld_o out, all driven straight from flops)
// ---------------------------------------------------------------------------
module onehot_sel_arbiter
   import onehot_sel_pkg::*;
#(
   parameter int NUM_PORTS = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   onehot_sel_arbiter_if.master  bus
);

   localparam int               IDX_W     = $clog2(NUM_PORTS);
   localparam logic [IDX_W-1:0] LAST_PORT = IDX_W'(NUM_PORTS - 1);

   sel_state_e           state_reg,    state_next;
   logic [NUM_PORTS-1:0] sel_reg,      sel_next;
   logic [IDX_W-1:0]     idx_reg,      idx_next;
   logic                 vld_reg,      vld_next;
   logic [IDX_W-1:0]     last_ptr_reg, last_ptr_next;

   logic [IDX_W-1:0]     pick_idx;
   logic                 pick_vld;
   logic                 release_grant;

   rr_pick #(
      .NUM_PORTS (NUM_PORTS),
      .IDX_W     (IDX_W)
   ) u_pick (
      .req      (bus.req_i),
      .last_ptr (last_ptr_reg),
      .winner   (pick_idx),
      .any_vld  (pick_vld)
   );

   // Completion pulse or owner withdrawal; both together is one release.
   assign release_grant = bus.done_i | ~bus.req_i[idx_reg];

   // Reset leaves last_ptr on the top port so port 0 is scanned first.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg    <= IDLE;
         sel_reg      <= '0;
         idx_reg      <= '0;
         vld_reg      <= 1'b0;
         last_ptr_reg <= LAST_PORT;
      end else begin
         state_reg    <= state_next;
         sel_reg      <= sel_next;
         idx_reg      <= idx_next;
         vld_reg      <= vld_next;
         last_ptr_reg <= last_ptr_next;
      end
   end

   always_comb begin
      state_next    = state_reg;
      sel_next      = sel_reg;
      idx_next      = idx_reg;
      vld_next      = vld_reg;
      last_ptr_next = last_ptr_reg;

      case (state_reg)
         IDLE: begin
            // done_i is meaningless here and deliberately not looked at.
            if (pick_vld) begin
               state_next = GRANT;
               sel_next   = NUM_PORTS'(1) << pick_idx;
               idx_next   = pick_idx;
               vld_next   = 1'b1;
            end
         end
         GRANT: begin
            // Requests from other ports are ignored while a grant is held.
            if (release_grant) begin
               state_next    = IDLE;
               sel_next      = '0;
               idx_next      = '0;
               vld_next      = 1'b0;
               last_ptr_next = idx_reg;
            end
         end
         default: begin
            state_next = IDLE;
            sel_next   = '0;
            idx_next   = '0;
            vld_next   = 1'b0;
         end
      endcase
   end

   assign bus.sel_o     = sel_reg;
   assign bus.sel_idx_o = idx_reg;
   assign bus.sel_vld_o = vld_reg;

   // Output invariants of the select bus.
   a_sel_onehot0: assert property (@(posedge clk) disable iff (reset)
      $onehot0(sel_reg));

   a_vld_matches: assert property (@(posedge clk) disable iff (reset)
      vld_reg == (|sel_reg));

   a_idx_matches: assert property (@(posedge clk) disable iff (reset)
      sel_reg == (NUM_PORTS'(vld_reg) << idx_reg));

   a_idx_decode: assert property (@(posedge clk) disable iff (reset)
      vld_reg |-> (onehot_to_idx(MAX_PORTS'(sel_reg)) == MAX_IDX_W'(idx_reg)));

endmodule

// File: tb/tb_onehot_sel_arbiter.sv
// ---------------------------------------------------------------------------
// tb_onehot_sel_arbiter
// Drives directed scenarios followed by random requests, done pulses and
// occasional resets; compares the select bus every cycle against a
// transaction-level round-robin model. Prints one line per grant.
// ---------------------------------------------------------------------------
module tb_onehot_sel_arbiter;

   localparam int N  = 4;
   localparam int IW = 2;

   logic clk = 1'b0;
   logic reset;

   always #5 clk = ~clk;

   onehot_sel_arbiter_if #(.NUM_PORTS(N)) bus ();

   onehot_sel_arbiter #(.NUM_PORTS(N)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int total = 0;
   int bad   = 0;

   // Reference model: who owns the mux, and who was served last.
   bit m_busy  = 1'b0;
   int m_owner = 0;
   int m_last  = N - 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic int rr_winner(input logic [N-1:0] r, input int last);
      for (int k = 1; k <= N; k++) begin
         if (r[(last + k) % N]) return (last + k) % N;
      end
      return -1;
   endfunction

   // One clock: apply inputs, let the DUT and the model take the edge,
   // then compare the registered outputs.
   task automatic cycle(input logic rst, input logic [N-1:0] r, input logic d);
      logic [N-1:0]  exp_sel;
      logic [IW-1:0] exp_idx;
      reset      = rst;
      bus.req_i  = r;
      bus.done_i = d;
      @(posedge clk);
      if (rst) begin
         m_busy = 1'b0;
         m_owner = 0;
         m_last = N - 1;
      end else if (!m_busy) begin
         if (r != '0) begin
            m_owner = rr_winner(r, m_last);
            m_busy  = 1'b1;
            $display("grant port %0d req=%b t=%0t", m_owner, r, $time);
         end
      end else if (d || !r[m_owner]) begin
         m_busy = 1'b0;
         m_last = m_owner;
      end
      #1;
      exp_sel = '0;
      exp_idx = '0;
      if (m_busy) begin
         exp_sel[m_owner] = 1'b1;
         exp_idx = IW'(m_owner);
      end
      check("sel", 32'(bus.sel_o), 32'(exp_sel));
      check("idx", 32'(bus.sel_idx_o), 32'(exp_idx));
      check("vld", 32'(bus.sel_vld_o), 32'(m_busy));
      check("onehot0", 32'($countones(bus.sel_o) <= 1), 32'd1);
   endtask

   initial begin
      logic [N-1:0] r;
      logic         d;
      logic         rst;

      // Reset with every port requesting.
      cycle(1'b1, 4'b1111, 1'b0);
      cycle(1'b1, 4'b1111, 1'b0);
      check("reset_sel", 32'(bus.sel_o), 32'd0);
      cycle(1'b0, 4'b1111, 1'b0);
      check("first_grant", 32'(bus.sel_o), 32'b0001);

      // Full rotation with done one cycle after each grant.
      for (int i = 0; i < 4; i++) begin
         cycle(1'b0, 4'b1111, 1'b1);
         cycle(1'b0, 4'b1111, 1'b0);
      end
      check("rotation_wrap", 32'(bus.sel_o), 32'b0001);

      // Lone requester on port 2 alternates with bubbles.
      cycle(1'b1, 4'b0000, 1'b0);
      for (int i = 0; i < 3; i++) begin
         cycle(1'b0, 4'b0100, 1'b0);
         check("lone_idx", 32'(bus.sel_idx_o), 32'd2);
         cycle(1'b0, 4'b0100, 1'b1);
      end

      // Owner withdraws without done; next grant wraps to port 0.
      cycle(1'b1, 4'b0000, 1'b0);
      cycle(1'b0, 4'b0010, 1'b0);
      cycle(1'b0, 4'b0011, 1'b0);
      check("hold_p1", 32'(bus.sel_o), 32'b0010);
      cycle(1'b0, 4'b0000, 1'b0);
      check("withdraw", 32'(bus.sel_o), 32'd0);
      cycle(1'b0, 4'b0011, 1'b0);
      check("after_withdraw", 32'(bus.sel_o), 32'b0001);

      // Reset in the middle of a grant on port 3.
      cycle(1'b1, 4'b0000, 1'b0);
      cycle(1'b0, 4'b1000, 1'b0);
      cycle(1'b1, 4'b1000, 1'b0);
      check("reset_mid_grant", 32'(bus.sel_o), 32'd0);
      cycle(1'b0, 4'b1000, 1'b0);
      check("regrant_p3", 32'(bus.sel_o), 32'b1000);

      // done in idle has no effect.
      cycle(1'b1, 4'b0000, 1'b0);
      cycle(1'b0, 4'b0000, 1'b1);
      cycle(1'b0, 4'b0010, 1'b0);
      check("idle_done", 32'(bus.sel_idx_o), 32'd1);

      // Random phase.
      for (int i = 0; i < 3000; i++) begin
         r = N'($urandom_range(0, (1 << N) - 1));
         if (m_busy && ($urandom_range(0, 3) != 0)) r[m_owner] = 1'b1;
         d   = ($urandom_range(0, 3) == 0);
         rst = ($urandom_range(0, 99) == 0);
         cycle(rst, r, d);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/onehot_sel_arbiter.md
Name: onehot_sel_arbiter

Overview:
- Sequential source for the one-hot select bus consumed by the team's 4:1 one-hot multiplexer.
- Arbitrates round-robin among NUM_PORTS requesters.
- Drives a registered, strictly one-hot select: at most one bit high, never any other pattern. It also drives the matching binary index and a valid flag.
- Holds each grant until the consumer signals completion, then rotates priority.

Parameters:
- NUM_PORTS, 4, number of requesters and width of the select bus; legal range 2..16.
- IDX_W, $clog2(NUM_PORTS), width of the binary index output; derived, not overridden.

Ports:
- clk, input, 1, single clock; all state updates on its rising edge.
- reset, input, 1, synchronous active-high reset.
- req_i, input, NUM_PORTS, level request per port; bit i means port i wants the mux.
- done_i, input, 1, consumer pulse: the current grant is finished.
- sel_o, output, NUM_PORTS, registered one-hot select; all-zero when no grant is held.
- sel_idx_o, output, IDX_W, binary index of the set bit in sel_o; 0 when sel_o is zero.
- sel_vld_o, output, 1, high exactly when sel_o is non-zero.

Behaviour:
- Reset:
  - Sampled only on the clk edge.
  - Next edge forces sel_o=0, sel_idx_o=0, sel_vld_o=0, state=IDLE, last_ptr=NUM_PORTS-1, so port 0 has first priority.
  - A reset during GRANT drops the grant on that same edge; no done_i is required.
- State machine has two states, IDLE and GRANT.
- IDLE:
  - If req_i==0, stay in IDLE; outputs stay zero.
  - Otherwise pick the winner: the first set bit of req_i scanning from last_ptr+1 upward, wrapping from NUM_PORTS-1 to 0.
  - On that edge, register sel_o=1<<winner, sel_idx_o=winner, sel_vld_o=1, and go to GRANT.
  - Latency: a request visible in an IDLE cycle produces the grant on the next rising edge (1 cycle).
- GRANT:
  - sel_o, sel_idx_o and sel_vld_o hold stable; changes on req_i of other ports are ignored.
  - Release condition: done_i=1, or req_i[sel_idx_o]=0 (owner withdrew).
  - On release: next edge clears all outputs to zero, sets last_ptr=sel_idx_o, and returns to IDLE.
  - If done_i and the owner's withdrawal coincide, it is a single release with the same result.
- Bubble: one IDLE cycle with sel_o=0 always separates consecutive grants. Back-to-back grants to different ports never overlap, and a make-before-break select is impossible.
- done_i while in IDLE is ignored and has no effect on last_ptr.
- Fairness: with all ports requesting continuously, grant order is 0,1,2,...,N-1,0,... A port requesting alone is re-granted after each bubble.
- Priority wrap-around: if last_ptr=N-1, the scan starts at 0. If only the port at last_ptr requests, it wins (full wrap).
- Invariants, checked by assertions:
  - $onehot0(sel_o) every cycle.
  - sel_vld_o == |sel_o.
  - sel_o == (sel_vld_o << sel_idx_o).
- No combinational path from any input to any output; all outputs are flops.

Decomposition:
- Shared package onehot_sel_pkg:
  - State enum sel_state_e {IDLE, GRANT}.
  - Function onehot_to_idx(), reused by checkers.
- Sub-module rr_pick:
  - Purely combinational rotate-and-priority-encode.
  - Inputs: req, last_ptr. Outputs: winner index, any-valid.
  - Instantiated once; keeps the FSM file small and lets rr_pick be unit-tested exhaustively.

Test Plan:
- Reset with req_i=4'b1111 held high → sel_o=0, sel_vld_o=0 on the first edge after reset; sel_o=4'b0001, sel_idx_o=0 on the first edge after reset deasserts.
- req_i=4'b1111 constant, done_i pulsed 1 cycle after each grant → sel_o sequence 0001,0000,0010,0000,0100,0000,1000,0000,0001; no cycle has two bits set.
- req_i=4'b0100 only, done_i pulsed each grant → sel_o alternates 0100/0000; sel_idx_o=2 whenever sel_vld_o=1.
- Grant held on port 1 (sel_o=0010); drop req_i[1] with no done_i → next edge sel_o=0000; the subsequent grant with req_i=4'b0011 goes to port 0 (wrap from last_ptr=1).
- Grant on port 3; assert reset for 1 cycle mid-grant → sel_o=0000 on that edge; afterwards req_i=4'b1000 yields a grant to port 3 with pointer restarted from port 0.
- done_i pulsed in IDLE with req_i=0 → outputs stay zero; the next request req_i=4'b0010 is granted as if no done_i occurred.
